// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 datapath width, reset vector and NOP encoding
package rv32_pkg;
   localparam int XLEN = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC = '0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, used for the instruction buffer and the request PC queue
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rdPtr, wrPtr;
   logic doPush, doPop;
   function automatic logic [AW-1:0] incr(input logic [AW-1:0] p);
      return p == AW'(DEPTH-1) ? '0 : p + AW'(1);
   endfunction
   always_comb begin
      empty = count == '0;
      full = count == CW'(DEPTH);
      doPop = pop && !empty;
      doPush = push && !full;
      dout = mem[rdPtr];
   end
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            mem[wrPtr] <= din;
            wrPtr <= incr(wrPtr);
         end
         if (doPop) rdPtr <= incr(rdPtr);
         count <= count + CW'(doPush) - CW'(doPop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction fetch; owns the PC, issues credit-limited word requests,
// buffers responses for decode and squashes wrong-path responses after a redirect.
module fetch_unit import rv32_pkg::*; #(
   parameter int                 XLEN     = rv32_pkg::XLEN,
   parameter logic [XLEN-1:0]    RESET_PC = rv32_pkg::RESET_PC,
   parameter int                 DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   input  logic            pcSel,
   input  logic [XLEN-1:0] pc_target
);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
   logic [XLEN-1:0] pc, pcqHead, bufPc;
   logic [31:0] bufInst;
   logic [CW-1:0] outstanding, dropCnt, outNext, bufCount, pcqCount;
   logic accept, rspKeep, bufPop, bufFull, bufEmpty, pcqFull, pcqEmpty;
   always_comb begin
      imem_req_valid = !rst && ({1'b0, outstanding} + {1'b0, bufCount}) < CAP;
      imem_req_addr = pc;
      accept = imem_req_valid && imem_req_ready;
      rspKeep = imem_rsp_valid && dropCnt == '0 && !pcSel;
      outNext = outstanding + CW'(accept) - CW'(imem_rsp_valid);
      inst_valid = !rst && !bufEmpty;
      bufPop = inst_valid && inst_ready;
      inst = inst_valid ? bufInst : NOP_INST;
      inst_pc = inst_valid ? bufPc : '0;
   end
   // a redirect drops every request still in flight, including one accepted this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
         outstanding <= '0;
         dropCnt <= '0;
      end else begin
         outstanding <= outNext;
         pc <= pcSel ? (pc_target & ~XLEN'(3)) : accept ? pc + XLEN'(4) : pc;
         dropCnt <= pcSel ? outNext : (imem_rsp_valid && dropCnt != '0) ? dropCnt - CW'(1) : dropCnt;
      end
   end
   fetch_fifo #(.WIDTH(32+XLEN), .DEPTH(DEPTH)) instBuf (
      .clk(clk), .rst(rst), .push(rspKeep), .pop(bufPop), .flush(pcSel),
      .din({imem_rsp_data, pcqHead}), .dout({bufInst, bufPc}),
      .full(bufFull), .empty(bufEmpty), .count(bufCount)
   );
   fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) pcQueue (
      .clk(clk), .rst(rst), .push(accept), .pop(rspKeep), .flush(pcSel),
      .din(pc), .dout(pcqHead),
      .full(pcqFull), .empty(pcqEmpty), .count(pcqCount)
   );
   bufOverflow: assert property (@(posedge clk) disable iff (rst) !(rspKeep && bufFull));
   pcqConsistent: assert property (@(posedge clk) disable iff (rst)
      !(accept && pcqFull) && !(rspKeep && pcqEmpty) && pcqCount == outstanding - dropCnt);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand-written redirect/reset sequences for fetch_unit
module tb_fetch_unit;
   localparam logic [31:0] KEY = 32'h5A00_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef struct {
      logic ir, rr, ev;
      logic [31:0] ea;
      logic eiv;
      logic [31:0] epc;
   } vec_t;
   logic clk, rst, imem_req_valid, imem_req_ready, imem_rsp_valid, inst_valid, inst_ready, pcSel;
   logic [31:0] imem_req_addr, imem_rsp_data, inst, inst_pc, pc_target;
   logic rspEn;
   logic [31:0] memQ[$];
   vec_t vecs[$];
   int nTests = 0, nFail = 0;
   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .pcSel(pcSel), .pc_target(pc_target)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic checkOut(string tag, logic ev, logic [31:0] ea, logic eiv, logic [31:0] epc);
      chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(ev));
      if (ev) chk({tag, " req_addr"}, imem_req_addr, ea);
      chk({tag, " inst_valid"}, 32'(inst_valid), 32'(eiv));
      chk({tag, " inst_pc"}, inst_pc, eiv ? epc : 32'h0);
      chk({tag, " inst"}, inst, eiv ? (epc ^ KEY) : NOP);
   endtask
   task automatic drive();
      imem_rsp_valid = rspEn && memQ.size() != 0;
      imem_rsp_data = memQ.size() != 0 ? (memQ[0] ^ KEY) : 32'h0;
   endtask
   // memory model: accepts are queued and answered one per cycle starting the next cycle
   task automatic tick();
      logic acc, had, wasRst;
      logic [31:0] a;
      acc = imem_req_valid && imem_req_ready;
      a = imem_req_addr;
      had = imem_rsp_valid;
      wasRst = rst;
      @(posedge clk);
      @(negedge clk);
      if (wasRst) memQ.delete();
      else begin
         if (had) void'(memQ.pop_front());
         if (acc) memQ.push_back(a);
      end
      drive();
      #1;
   endtask
   task automatic waitReq(string tag, logic [31:0] addr);
      for (int k = 0; k < 20 && !imem_req_valid; k++) tick();
      chk({tag, " req_valid"}, 32'(imem_req_valid), 32'h1);
      chk({tag, " req_addr"}, imem_req_addr, addr);
   endtask
   task automatic waitInst(string tag, logic [31:0] pc);
      for (int k = 0; k < 20 && !inst_valid; k++) tick();
      chk({tag, " inst_valid"}, 32'(inst_valid), 32'h1);
      chk({tag, " inst_pc"}, inst_pc, pc);
      chk({tag, " inst"}, inst, pc ^ KEY);
      tick();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic found;
      //             ir    rr    ev    ea          eiv   epc
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h18, 1'b0, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h14});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h18});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h00});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h1C});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h24, 1'b0, 32'h00});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h20});
      rst = 1'b1;
      rspEn = 1'b1;
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      pcSel = 1'b0;
      pc_target = 32'h0;
      drive();
      tick();
      tick();
      checkOut("reset", 1'b0, 32'h0, 1'b0, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         inst_ready = vecs[i].ir;
         imem_req_ready = vecs[i].rr;
         #1;
         checkOut($sformatf("row%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].eiv, vecs[i].epc);
         tick();
      end
      inst_ready = 1'b1;
      imem_req_ready = 1'b1;
      rspEn = 1'b0;
      drive();
      tick();
      tick();
      chk("redir1 credit full", 32'(imem_req_valid), 32'h0);
      pcSel = 1'b1;
      pc_target = 32'h100;
      tick();
      pcSel = 1'b0;
      rspEn = 1'b1;
      drive();
      waitReq("redir1", 32'h100);
      waitInst("redir1 first", 32'h100);
      waitInst("redir1 second", 32'h104);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (imem_rsp_valid && imem_req_valid) found = 1'b1;
         else tick();
      end
      chk("redir2 rsp+accept cycle", 32'(found), 32'h1);
      pcSel = 1'b1;
      pc_target = 32'h203;
      tick();
      pcSel = 1'b0;
      waitReq("redir2", 32'h200);
      waitInst("redir2 first", 32'h200);
      waitInst("redir2 second", 32'h204);
      inst_ready = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      chk("stall inst_valid", 32'(inst_valid), 32'h1);
      chk("stall req_valid", 32'(imem_req_valid), 32'h0);
      rspEn = 1'b0;
      rst = 1'b1;
      drive();
      #1;
      checkOut("rst-now", 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      checkOut("rst-held", 1'b0, 32'h0, 1'b0, 32'h0);
      rst = 1'b0;
      rspEn = 1'b1;
      drive();
      #1;
      checkOut("post-rst", 1'b1, 32'h0, 1'b0, 32'h0);
      inst_ready = 1'b1;
      waitInst("post-rst first", 32'h0);
      waitInst("post-rst second", 32'h4);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the RV32 pipeline. It owns the PC and issues in-order word requests to instruction memory. It buffers returned instructions and presents them, with their PC, to the decode/control stage. It consumes the pcSel/ALU-target redirect that the control path produces, and discards wrong-path instructions still in flight when a redirect occurs.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, instruction buffer entries; also the cap on outstanding requests plus buffered entries

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order, at most one per cycle, never back-pressured
imem_rsp_data  in  32  returned instruction word
inst  out  32  instruction to decode; NOP_INST when inst_valid=0
inst_pc  out  XLEN  PC of inst
inst_valid  out  1  inst/inst_pc valid
inst_ready  in  1  decode accepts (low = pipeline stall)
pcSel  in  1  redirect request from control (taken branch/jump)
pc_target  in  XLEN  redirect target (ALU result)

Behaviour:
- Reset (rst high at the edge): pc=RESET_PC, buffer empty, outstanding=0, drop_cnt=0.
  - While rst is high: imem_req_valid=0, inst_valid=0, inst=NOP_INST, inst_pc=0.
  - First request (addr RESET_PC) is asserted in the first cycle after rst deasserts.
- Request handshake: a request is accepted when imem_req_valid && imem_req_ready.
  - imem_req_addr=pc.
  - On acceptance: pc<=pc+4 (wraps modulo 2^XLEN), outstanding++.
- Credit: imem_req_valid = !rst && (outstanding + count) < DEPTH.
  - Computed from registered state only; a same-cycle pop does not free credit.
  - imem_req_valid does not depend on pcSel, imem_rsp_valid or inst_ready.
  - Once asserted, the request holds addr stable until accepted, unless a redirect occurs.
- Response: each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: the response is discarded and drop_cnt--.
  - Otherwise: {data, pc_of_req} is pushed into the buffer.
  - The request PC travels with the request through a small in-order PC queue of DEPTH entries inside the block.
- Decode output: the buffer head drives inst/inst_pc; inst_valid = !empty.
  - Pop on inst_valid && inst_ready.
  - Zero-latency bypass is not required; minimum latency from response to inst_valid is 1 cycle.
- Redirect (pcSel=1 at an edge, not in reset):
  - pc<=pc_target with bits [1:0] forced to 0.
  - Buffer flushed; PC queue flushed.
  - drop_cnt<=outstanding after this cycle's accept/response accounting, so every request issued with an old address is dropped, including one accepted this same cycle.
  - The new-target request may assert the next cycle, subject to credit.
- Simultaneous events:
  - Redirect + pop: redirect wins; the popped instruction still counts as consumed by decode.
  - Redirect + response in the same cycle: the response is dropped.
  - Push + pop in the same cycle: count unchanged.
  - Buffer overflow is impossible by credit; an assertion flags push when full.
- Reset mid-operation: all state is cleared. Responses to pre-reset requests are illegal (the memory is reset together with the block).
- Registers: outstanding and drop_cnt are each clog2(DEPTH+1) bits.

Decomposition:
- Package rv32_pkg holds XLEN, NOP_INST = 32'h0000_0013 (addi x0,x0,0) and the default RESET_PC.
- One sub-module: fetch_fifo.
  - Synchronous FIFO, DEPTH entries, width 32+XLEN.
  - push/pop/flush inputs, full/empty/count outputs.
  - Reused for the PC queue.

Test Plan:
- Reset then memory always ready with 1-cycle response, inst_ready=1 → requests at 0x0,0x4,0x8…; inst_pc follows the same sequence with matching data; inst=0x00000013 while rst is high.
- inst_ready=0 for 5 cycles → buffer fills to 2; imem_req_valid drops once outstanding+count=2; no instruction is lost or duplicated after release.
- Two requests outstanding (0x10,0x14), pcSel=1 with pc_target=0x100 → both responses discarded; next inst_pc=0x100, then 0x104.
- pcSel=1 in the same cycle as a response and a request accept, pc_target=0x203 → that response and the accepted request's response are both dropped; next request addr=0x200.
- imem_req_ready low for 3 cycles → imem_req_valid held high, addr held stable; pc advances only on acceptance.
- rst asserted mid-stream with a full buffer → the next cycle has inst_valid=0 and imem_req_valid=0; after release the first request addr=RESET_PC.
